// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter that shares one WIDTH-bit add/subtract datapath (IDLE -> EXEC -> RESP).
// Optional signed-overflow output rsp_ovf is enabled by defining ADDSUB_ARB_OVF_EN.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       valid_vec;
    logic [1:0]       ready_vec;
    logic [1:0]       op_vec;
    logic [WIDTH-1:0] a_vec [2];
    logic [WIDTH-1:0] b_vec [2];

    logic             last_reg;
    logic             grant_id;
    logic             grant_any;
    logic             handshake;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             op_reg;
    logic             id_reg;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    assign valid_vec = {req1_valid, req0_valid};
    assign op_vec    = {req1_op, req0_op};
    assign a_vec[0]  = req0_a;
    assign a_vec[1]  = req1_a;
    assign b_vec[0]  = req0_b;
    assign b_vec[1]  = req1_b;

    // Under contention the requester not served last wins; a lone requester always wins.
    assign grant_any = |valid_vec;
    assign grant_id  = (valid_vec == 2'b11) ? ~last_reg : valid_vec[1];
    assign handshake = (state_reg == IDLE) && grant_any;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && valid_vec[gi] && (grant_id == gi[0]);
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // Subtract is a + ~b + 1, so carry-out of 1 means no borrow.
    assign b_eff = b_reg ^ {WIDTH{op_reg}};
    assign sum   = {1'b0, a_reg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_reg};
    assign ovf   = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state_reg == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                a_reg    <= a_vec[grant_id];
                b_reg    <= b_vec[grant_id];
                op_reg   <= op_vec[grant_id];
                id_reg   <= grant_id;
                last_reg <= grant_id;
            end
        end
    end

    // Response registers only change in EXEC, so they stay stable throughout RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result <= sum[WIDTH-1:0];
            rsp_carry  <= sum[WIDTH];
            rsp_id     <= id_reg;
        end
    end

`ifdef ADDSUB_ARB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_ovf <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_ovf <= ovf;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized transactions
// checked against an arithmetic reference model of the arbiter and datapath.
module tb_addsub_arbiter;

    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req0_op = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0, req1_op = 1'b0;
    logic [W-1:0] req1_a = '0, req1_b = '0;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
`ifdef ADDSUB_ARB_OVF_EN
    logic         rsp_ovf;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int last_grant = 1;

    addsub_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry)
`ifdef ADDSUB_ARB_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed view for overflow.
    function automatic void model(input int a, input int b, input int op,
                                  output int res, output int c, output int ov);
        int sa, sb, sr;
        if (op == 0) begin
            res = (a + b) % M;
            c   = ((a + b) >= M) ? 1 : 0;
        end else begin
            res = (a - b + M) % M;
            c   = (a >= b) ? 1 : 0;
        end
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        sr = (op == 0) ? sa + sb : sa - sb;
        ov = (sr > H - 1 || sr < -H) ? 1 : 0;
    endfunction

    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) return (last_grant == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    // One full transaction: request, handshake, EXEC, RESP (held 'hold' cycles), accept.
    task automatic issue(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic op0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1,
                         input int hold, output int got_id);
        int g, ea, eb, eop, er, ec, eo;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        #1;
        g = pick(v0, v1);
        check("grant_ready0", req0_ready, (g == 0) ? 1 : 0);
        check("grant_ready1", req1_ready, (g == 1) ? 1 : 0);
        @(posedge clk); #1;
        last_grant = g;
        if (g == 0) begin
            ea = a0; eb = b0; eop = op0; req0_valid = 1'b0;
        end else begin
            ea = a1; eb = b1; eop = op1; req1_valid = 1'b0;
        end
        model(ea, eb, eop, er, ec, eo);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_readys", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        check("resp_valid", rsp_valid, 1);
        check("resp_id", rsp_id, g);
        check("resp_result", rsp_result, er);
        check("resp_carry", rsp_carry, ec);
`ifdef ADDSUB_ARB_OVF_EN
        check("resp_ovf", rsp_ovf, eo);
`endif
        got_id = int'(rsp_id);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, er);
            check("hold_carry", rsp_carry, ec);
            check("hold_readys", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("after_accept_valid", rsp_valid, 0);
        $display("txn id=%0d a=%0h b=%0h op=%0d -> result=%0h carry=%0d (exp %0h/%0d) hold=%0d",
                 g, ea, eb, eop, rsp_result, rsp_carry, er, ec, hold);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant = 1;
    endtask

    initial begin
        int id;
        int ids [6];
        int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
        logic [W-1:0] ra0, rb0, ra1, rb1;
        logic rop0, rop1;
        int v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_carry", rsp_carry, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_readys", {req0_ready, req1_ready}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single add / subtract
        issue(1'b1, 4'b1010, 4'b0101, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0, id);
        issue(1'b1, 4'b1010, 4'b0101, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 0, id);

        // Contention straight after reset: requester 0 first
        do_reset();
        issue(1'b1, 4'b1110, 4'b0111, 1'b0, 1'b1, 4'b0010, 4'b0001, 1'b1, 0, id);
        check("contention_first_id", id, 0);
        issue(1'b0, 4'b1110, 4'b0111, 1'b0, 1'b1, 4'b0010, 4'b0001, 1'b1, 0, id);
        check("contention_second_id", id, 1);

        // Fairness with both continuously valid
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ra0 = W'($urandom); rb0 = W'($urandom); rop0 = 1'($urandom);
            ra1 = W'($urandom); rb1 = W'($urandom); rop1 = 1'($urandom);
            issue(1'b1, ra0, rb0, rop0, 1'b1, ra1, rb1, rop1, 0, id);
            ids[i] = id;
        end
        for (int i = 0; i < 6; i++) check("fair_id_seq", ids[i], exp_seq[i]);

        // Backpressure with borrow
        issue(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0101, 4'b1110, 1'b1, 5, id);

        // Reset during EXEC discards the transaction
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h4; req0_op = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_result", rsp_result, 0);
        check("midrst_id", rsp_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", rsp_valid, 0);
        end
        issue(1'b1, 4'h2, 4'h3, 1'b0, 1'b1, 4'h9, 4'h1, 1'b1, 0, id);
        check("midrst_grant0", id, 0);

        // Valid dropped before handshake: no grant, pointer unchanged
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        check("drop_ready1", req1_ready, 1);
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("drop_no_txn", rsp_valid, 0);
        @(posedge clk); #1;
        check("drop_still_idle", rsp_valid, 0);
        issue(1'b1, 4'h5, 4'h5, 1'b1, 1'b1, 4'h9, 4'h1, 1'b1, 0, id);
        check("drop_ptr_kept", id, 1);

        // Signed-overflow boundaries
        issue(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0, id);
        issue(1'b1, 4'b0111, 4'b1000, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 0, id);
        issue(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0, id);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            v = $urandom_range(1, 3);
            ra0 = W'($urandom); rb0 = W'($urandom); rop0 = 1'($urandom);
            ra1 = W'($urandom); rb1 = W'($urandom); rop1 = 1'($urandom);
            issue(v[0], ra0, rb0, rop0, v[1], ra1, rb1, rop1, $urandom_range(0, 3), id);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a  input  WIDTH  requester 0 operand A.
REQ-006 req0_b  input  WIDTH  requester 0 operand B.
REQ-007 req0_op  input  1  requester 0 operation: 0 = add, 1 = subtract.
REQ-008 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-009 req1_valid, req1_a, req1_b, req1_op, req1_ready SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  response holds a valid result.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 rsp_carry  output  1  carry-out; for subtract, 1 = no borrow, 0 = borrow.

Function
REQ-015 The block SHALL share one WIDTH-bit add/subtract datapath between two requesters, using an FSM with states IDLE, EXEC and RESP.
REQ-016 IDLE: the block SHALL grant exactly one valid requester and assert only that requester's ready, combinationally, in the same cycle.
REQ-017 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; a lone valid requester is always granted.
REQ-018 On handshake (valid & ready), the block SHALL capture a, b, op and the requester id, then move to EXEC.
REQ-019 EXEC, one cycle: {carry, result} SHALL equal a + (b XOR {WIDTH{op}}) + op, registered, and the FSM moves to RESP.
REQ-020 RESP: rsp_valid SHALL be 1, and rsp_id, rsp_result and rsp_carry SHALL hold stable until rsp_valid & rsp_ready.
REQ-021 On response acceptance, the FSM SHALL return to IDLE; a new grant is possible in the following cycle.
REQ-022 Latency: a handshake at cycle N SHALL give rsp_valid = 1 at cycle N+2; minimum spacing between accepted requests is 3 cycles.
REQ-023 Both ready outputs SHALL be 0 in EXEC and RESP.
REQ-024 Requesters SHALL hold valid and operands until ready; a valid drop without handshake SHALL cause no grant and no update of the round-robin pointer.
REQ-025 Wrap-around: results SHALL be truncated to WIDTH bits with the overflow bit in rsp_carry only (1111 + 1111 -> 1110, carry 1).

Reset
REQ-026 Asserting rst SHALL immediately force IDLE, rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_id = 0, and set the round-robin pointer so requester 0 wins the first contention.
REQ-027 Reset during EXEC or RESP SHALL discard the transaction with no response produced.

Configuration
REQ-028 With macro ADDSUB_ARB_OVF_EN defined, the block SHALL add output rsp_ovf (1 bit) giving two's-complement signed overflow of the operation, registered with rsp_result and reset to 0.
REQ-029 Without ADDSUB_ARB_OVF_EN, rsp_ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Single add/sub: req0 add 1010+0101 -> rsp_result 1111, carry 0, id 0 at N+2; then req0 sub 1010-0101 -> 0101, carry 1.
REQ-031 Contention: after reset, both valid in the same cycle (req0 add 1110+0111, req1 sub 0010-0001) -> first response id 0 (0101, carry 1), second response id 1 (0001, carry 1).
REQ-032 Fairness: both requesters continuously valid for 6 transactions -> rsp_id sequence 0,1,0,1,0,1.
REQ-033 Backpressure and borrow: req1 sub 0101-1110 with rsp_ready held 0 for 5 cycles -> rsp_result 0111 and carry 0 held stable, both ready outputs 0 throughout.
REQ-034 Reset mid-operation: rst pulsed during EXEC -> rsp_valid stays 0 and the next contention grants requester 0.
REQ-035 With ADDSUB_ARB_OVF_EN: add 0111+0001 -> 1000, ovf 1; sub 0111-1000 -> 1111, ovf 1; add 1111+1111 -> 1110, ovf 0.
